// File: rtl/fb_pkg.sv
// Framebuffer geometry and write-engine types shared with the VGA scan-out engine.
// FB_WRITER_DECIMATE_EN selects 2:1 decimation of a double-size input raster.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned PIX_W     = 3;

`ifdef FB_WRITER_DECIMATE_EN
    localparam int unsigned DEC = 2;
`else
    localparam int unsigned DEC = 1;
`endif

    // Input raster size; line checks and padding run in input coordinates.
    localparam int unsigned IN_W  = FB_WIDTH * DEC;
    localparam int unsigned IN_H  = FB_HEIGHT * DEC;
    localparam int unsigned COL_W = $clog2(IN_W + 1);
    localparam int unsigned ROW_W = $clog2(IN_H + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DROP,
        ST_PAD
    } fb_writer_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } fb_wr_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Input row/column tracking and running framebuffer write address.
// The address only advances on real writes, so no multiplier is needed.
module fb_addr_gen
    import fb_pkg::*;
(
    input  logic              vga_clk_25,
    input  logic              reset_n,
    input  logic              start,
    input  logic              step,
    input  logic              close,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              col_last,
    output logic              col_end,
    output logic              row_last,
    output logic              pix_kept
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // start means pixel (0,0) has just been consumed and written
    always_ff @(posedge vga_clk_25) begin
        if (!reset_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (start) begin
            col  <= COL_W'(1);
            row  <= '0;
            addr <= ADDR_W'(1);
        end else begin
            if (close) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else if (step) begin
                col <= col + COL_W'(1);
            end
            if (inc) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign col_last = (col == COL_W'(IN_W - 1));
    assign col_end  = (col == COL_W'(IN_W));
    assign row_last = (row == ROW_W'(IN_H - 1));
    assign pix_kept = (DEC == 1) || (!row[0] && !col[0]);

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write engine: raster pixel stream in, exactly one full frame of writes out.
// Build with FB_WRITER_DECIMATE_EN to accept 2x-size frames and keep even rows/columns.
module fb_writer
    import fb_pkg::*;
(
    input  logic              vga_clk_25,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic              line_err,
    output logic              busy
);

    fb_writer_state_t state;
    fb_writer_state_t nxt;

    logic              xfer;
    logic              wr_v;
    fb_wr_t            wr;
    logic              restart;
    logic              start;
    logic              step;
    logic              close;
    logic              err;
    logic              done;
    logic              done_pend;
    logic [ADDR_W-1:0] addr;
    logic              col_last;
    logic              col_end;
    logic              row_last;
    logic              pix_kept;

    assign xfer = s_valid && s_ready;

    fb_addr_gen u_addr_gen (
        .vga_clk_25 (vga_clk_25),
        .reset_n    (reset_n),
        .start      (start),
        .step       (step),
        .close      (close),
        .inc        (wr_v),
        .addr       (addr),
        .col_last   (col_last),
        .col_end    (col_end),
        .row_last   (row_last),
        .pix_kept   (pix_kept)
    );

    // Next-state and write decode
    always_comb begin
        nxt     = state;
        wr_v    = 1'b0;
        wr.addr = addr;
        wr.data = '0;
        restart = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        close   = 1'b0;
        err     = 1'b0;
        done    = 1'b0;

        case (state)
            ST_IDLE: begin
                restart = xfer && s_sof && enable;
            end
            ST_WRITE: begin
                if (xfer) begin
                    if (s_sof) begin
                        restart = 1'b1;
                        err     = 1'b1;
                    end else if (col_end) begin
                        err = 1'b1;
                        if (s_eol) close = 1'b1;
                        else       nxt   = ST_DROP;
                    end else begin
                        wr_v    = pix_kept;
                        wr.data = s_data;
                        if (s_eol && !col_last) begin
                            err  = 1'b1;
                            step = 1'b1;
                            nxt  = ST_PAD;
                        end else if (s_eol) begin
                            close = 1'b1;
                        end else begin
                            step = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (xfer) begin
                    if (s_sof) begin
                        restart = 1'b1;
                        err     = 1'b1;
                    end else if (s_eol) begin
                        close = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                // A held sof aborts the pad; IDLE then accepts it and writes it at address 0.
                if (s_valid && s_sof) begin
                    err = 1'b1;
                    nxt = ST_IDLE;
                end else begin
                    wr_v = pix_kept;
                    if (col_last) close = 1'b1;
                    else          step  = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase

        if (restart) begin
            wr_v    = 1'b1;
            wr.addr = '0;
            wr.data = s_data;
            start   = 1'b1;
            nxt     = s_eol ? ST_PAD : ST_WRITE;
            if (s_eol) err = 1'b1;
        end

        if (close) begin
            nxt  = row_last ? ST_IDLE : ST_WRITE;
            done = row_last;
        end
    end

    // State and registered outputs; frame_done trails the final write by one cycle
    always_ff @(posedge vga_clk_25) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            line_err   <= 1'b0;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt;
            s_ready    <= (nxt != ST_PAD);
            busy       <= (nxt != ST_IDLE);
            wr_en      <= wr_v;
            line_err   <= err;
            done_pend  <= done;
            frame_done <= done_pend;
            if (wr_v) begin
                wr_addr <= wr.addr;
                wr_data <= wr.data;
            end
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: line table, reset/abort sequences and a full frame.
module tb_fb_writer;
    import fb_pkg::*;

    localparam int WAIT_MAX = 1000;
    localparam int LAST     = FB_WIDTH * FB_HEIGHT - 1;

    logic              vga_clk_25;
    logic              reset_n;
    logic              enable;
    logic              s_valid;
    logic              s_ready;
    logic [PIX_W-1:0]  s_data;
    logic              s_sof;
    logic              s_eol;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              frame_done;
    logic              line_err;
    logic              busy;

    fb_writer dut (
        .vga_clk_25 (vga_clk_25),
        .reset_n    (reset_n),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .line_err   (line_err),
        .busy       (busy)
    );

    initial vga_clk_25 = 1'b0;
    always #20 vga_clk_25 = ~vga_clk_25;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    typedef struct {
        int row;
        int len;
        bit eol;
        int wait_exp;
        int err_exp;
    } line_t;

    exp_t  exp_q[$];
    line_t tab[11];

    int total    = 0;
    int bad      = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    int done_cnt = 0;
    int last_addr = -1;
    bit prev_wr  = 1'b0;
    int prev_addr = -1;

    function automatic int fb_addr(input int row, input int col);
        return (row / int'(DEC)) * int'(FB_WIDTH) + col / int'(DEC);
    endfunction

    function automatic bit kept(input int row, input int col);
        return (DEC == 1) || ((row % 2 == 0) && (col % 2 == 0));
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
        end
    endtask

    task automatic report();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // One clock; outputs sampled at the falling edge and scored against the queue
    task automatic tick();
        exp_t e;
        @(negedge vga_clk_25);
        if (wr_en) begin
            check("wr_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
            end
            wr_cnt++;
            last_addr = int'(wr_addr);
        end
        if (line_err) err_cnt++;
        if (frame_done) begin
            done_cnt++;
            check("done_after_last_wr", int'(prev_wr && prev_addr == LAST), 1);
        end
        prev_wr   = wr_en;
        prev_addr = int'(wr_addr);
    endtask

    task automatic push_pix(input int d, input bit sof, input bit eol, output int waits);
        s_valid = 1'b1;
        s_data  = PIX_W'(d);
        s_sof   = sof;
        s_eol   = eol;
        waits   = 0;
        while (!s_ready && waits < WAIT_MAX) begin
            tick();
            waits++;
        end
        if (waits >= WAIT_MAX) begin
            check("ready_timeout", waits, 0);
            report();
        end
        tick();
        s_sof = 1'b0;
        s_eol = 1'b0;
    endtask

    task automatic send_line(input int row, input int len, input bit eol, input bit sof,
                             input bit rnd, output int waits);
        int w;
        int d;
        waits = 0;
        for (int c = 0; c < len; c++) begin
            d = rnd ? int'($urandom_range(0, 7)) : (fb_addr(row, c) & 7);
            if (c < int'(IN_W) && kept(row, c)) exp_q.push_back('{fb_addr(row, c), d});
            push_pix(d, sof && c == 0, eol && c == len - 1, w);
            waits += w;
        end
        if (eol && len < int'(IN_W)) begin
            for (int c = len; c < int'(IN_W); c++) begin
                if (kept(row, c)) exp_q.push_back('{fb_addr(row, c), 0});
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        int w;
        int base;

        for (int i = 0; i < 11; i++) tab[i] = '{i, int'(IN_W), 1'b1, 0, (i >= 5) ? 2 : 1};
        tab[0].len      = 100;
        tab[1].wait_exp = int'(IN_W) - 100;
        tab[5].len      = int'(IN_W) + 10;
        tab[10].len     = 50;
        tab[10].eol     = 1'b0;

        reset_n = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        repeat (3) tick();
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_line_err", int'(line_err), 0);
        check("rst_busy", int'(busy), 0);

        reset_n = 1'b1;
        tick();
        check("s_ready_after_rst", int'(s_ready), 1);

        // sof while disarmed is discarded
        push_pix(5, 1'b1, 1'b0, w);
        s_valid = 1'b0;
        tick();
        check("idle_disabled_busy", int'(busy), 0);
        check("idle_disabled_err", err_cnt, 0);

        // Partial frame, then reset in the middle of a line
        enable = 1'b1;
        for (int r = 0; r < 3; r++) begin
            send_line(r, int'(IN_W), 1'b1, r == 0, 1'b1, w);
            check("rf_wait", w, 0);
        end
        send_line(3, 100, 1'b0, 1'b0, 1'b1, w);
        check("rf_busy", int'(busy), 1);
        s_valid = 1'b1;
        s_data  = PIX_W'(3);
        reset_n = 1'b0;
        tick();
        check("mid_rst_wr_en", int'(wr_en), 0);
        check("mid_rst_wr_addr", int'(wr_addr), 0);
        check("mid_rst_wr_data", int'(wr_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_s_ready", int'(s_ready), 0);
        tick();
        reset_n = 1'b1;
        s_valid = 1'b0;
        tick();
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_done", done_cnt, 0);
        check("mid_rst_q", exp_q.size(), 0);

        // Frame with short line, long line and a mid-frame sof
        for (int i = 0; i < 11; i++) begin
            send_line(tab[i].row, tab[i].len, tab[i].eol, i == 0, 1'b1, w);
            check($sformatf("ready_wait_row%0d", tab[i].row), w, tab[i].wait_exp);
            check($sformatf("line_err_row%0d", tab[i].row), err_cnt, tab[i].err_exp);
        end

        // The restarting sof opens a clean full frame
        base = wr_cnt;
        send_line(0, int'(IN_W), 1'b1, 1'b1, 1'b0, w);
        check("abort_err", err_cnt, 3);
        check("abort_no_done", done_cnt, 0);
        for (int r = 1; r < int'(IN_H); r++) begin
            send_line(r, int'(IN_W), 1'b1, 1'b0, 1'b0, w);
            if (w != 0) check($sformatf("full_wait_row%0d", r), w, 0);
        end
        for (int k = 0; k < 8 && done_cnt == 0; k++) tick();
        check("full_done", done_cnt, 1);
        repeat (3) tick();
        check("full_done_once", done_cnt, 1);
        check("full_writes", wr_cnt - base, int'(FB_WIDTH * FB_HEIGHT));
        check("full_last_addr", last_addr, LAST);
        check("full_err", err_cnt, 3);
        check("full_q_empty", exp_q.size(), 0);
        check("full_busy", int'(busy), 0);
        check("full_s_ready", int'(s_ready), 1);

        report();
    end

endmodule

// File: doc/fb_writer.md
# fb_writer

Framebuffer write-side engine: accepts a raster-ordered 3-bit pixel stream over a valid/ready handshake and writes it into the 320x240 framebuffer RAM write port. The VGA scan-out engine reads this framebuffer. fb_writer guarantees that every accepted frame produces exactly FB_WIDTH x FB_HEIGHT writes at linear addresses, even when the source sends short lines, long lines or truncated frames.

## Interface
- FB_WIDTH, 320, framebuffer columns
- FB_HEIGHT, 240, framebuffer rows
- ADDR_W, 17, write address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT
- PIX_W, 3, pixel width

- vga_clk_25  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  arm capture; sampled only in IDLE
- s_valid  in  1  source pixel valid
- s_ready  out  1  sink ready; a transfer occurs when s_valid && s_ready
- s_data  in  PIX_W  pixel value
- s_sof  in  1  first pixel of frame; qualified by transfer
- s_eol  in  1  last pixel of line; qualified by transfer
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  PIX_W  RAM write data
- frame_done  out  1  one-cycle pulse after the last write of a frame
- line_err  out  1  one-cycle pulse per malformed line or aborted frame
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WRITE, DROP, PAD.
- IDLE: s_ready=1. Transfers without s_sof are discarded. A transfer with s_sof while enable=1 writes that pixel at address 0, sets col=1 and row=0, and moves to WRITE.
- WRITE: s_ready=1. Each transfer writes to addr=row*FB_WIDTH+col. The address is a running counter; no multiplier is used. col then increments.
- Short line: s_eol arrives with col+1 < FB_WIDTH. The eol pixel is written, line_err pulses, and the block enters PAD.
- PAD: s_ready=0. Writes 0 to the remaining columns, one per cycle, then closes the line.
- Long line: a transfer arrives with col == FB_WIDTH and no eol. The block enters DROP and pulses line_err once.
- DROP: s_ready=1. Pixels are discarded until s_eol, then the line is closed.
- Line close: col=0 and row increments. If row was FB_HEIGHT-1, frame_done pulses on the cycle after the final write, and the block returns to IDLE.
- s_sof in WRITE, DROP or PAD (PAD only if s_valid is high during the pad): line_err pulses and the frame restarts. That pixel is written at address 0, and row and col restart. No padding of the aborted frame.
- s_sof together with s_eol on the same pixel: treated as a one-pixel line (short line rules).
- Address never exceeds FB_WIDTH*FB_HEIGHT-1. Counters wrap only through IDLE.

## Timing
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, line_err=0, busy=0. State is IDLE, and s_ready rises on the first cycle after reset.
- Write latency: wr_en, wr_addr and wr_data are registered and appear 1 cycle after the accepting edge.
- s_ready depends only on state, never on s_valid.
- PAD of N pixels holds s_ready=0 for exactly N cycles. The line close is in the last pad cycle.
- Reset asserted mid-frame: abandon immediately with no further writes and no frame_done.

## Configuration
- FB_WRITER_DECIMATE_EN defined:
  - Input frames are 2*FB_WIDTH x 2*FB_HEIGHT.
  - Only even input columns of even input rows are written. Odd rows are consumed with no writes.
  - Line-length checks and padding use the input width; padding writes only the even columns it covers.
- Undefined: 1:1 mapping.

## Structure
- Shared package fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT, ADDR_W, PIX_W defaults, shared with the VGA scan-out engine.
  - The fb_writer_state_t enum.
- Sub-module fb_addr_gen: row/col/address counters with line-close and restart controls. The FSM stays in fb_writer.

## Test plan
- Full frame:
  - Stimulus: 320x240 pixels, data=addr[2:0], eol on col 319, sof on the first pixel.
  - Required: 76800 writes, last wr_addr=76799, one frame_done, no line_err.
- Short line:
  - Stimulus: row 0 eol at col 99.
  - Required: 220 writes of 0 at addresses 100..319, s_ready=0 for 220 cycles, one line_err; row 1 starts at address 320.
- Long line:
  - Stimulus: row 5 has 330 pixels.
  - Required: 320 writes for that row, 10 pixels discarded with s_ready=1, one line_err; row 6 starts at 1920.
- Mid-frame sof:
  - Stimulus: sof at row 10, col 50.
  - Required: line_err, that pixel written at address 0, no frame_done for the aborted frame.
- Reset mid-frame:
  - Stimulus: reset_n=0 at row 100.
  - Required: wr_en=0 the next cycle, all outputs 0, then a clean full frame on re-sof.
- FB_WRITER_DECIMATE_EN:
  - Stimulus: 640x480 frame.
  - Required: 76800 writes, input (2r,2c) lands at address r*320+c.
